ll_walk_sched: RTL and testbench
================================

// Module: ll_walk_sched
// PURPOSE
//   Shares one linked-list walker between NREQ requesters. Each requester offers a start pointer.
//   A round-robin arbiter picks one list; the block walks it through an internal next-pointer table
//   and streams one node pointer per accepted beat, tagged with requester id and a last flag.
//   Successive lists are emitted back-to-back with no bubble. Pointer 0 is NULL (list terminator).
//   The table is loaded through a config port.
// PARAMETERS
//   NREQ   4   number of requesters (>=2)
//   n      16  node count / next-table depth (from package)
//   w_ptr  $clog2(n)  pointer width (from package)
// PORTS
//   clk        in   1            clock
//   rst        in   1            synchronous, active-high reset
//   req_start  in   NREQ*w_ptr   per-requester start pointer (ptr_t [NREQ])
//   req_vld    in   NREQ         per-requester start valid
//   req_rdy    out  NREQ         one-hot grant; start consumed when req_vld[i] & req_rdy[i]
//   cfg_we     in   1            next-table write strobe
//   cfg_addr   in   w_ptr        table index to write
//   cfg_next   in   w_ptr        next pointer to store
//   cfg_rdy    out  1            high when table writes are accepted (= ~out_vld)
//   out_ptr    out  w_ptr        current node pointer
//   out_id     out  $clog2(NREQ) requester owning out_ptr
//   out_last   out  1            out_ptr is the final node of its list
//   out_vld    out  1            output beat valid
//   out_rdy    in   1            downstream accepts beat
//   loop_err   out  1            sticky: a walk hit the n-node limit without reaching NULL
// BEHAVIOUR
//   - Reset: out_vld=0, out_ptr=0, out_id=0, out_last=0, loop_err=0, RR pointer=0,
//     walk counter=0, whole next table=0. Reset mid-walk aborts the walk silently.
//   - Output register loads when adv = ~out_vld | out_rdy; otherwise all outputs hold stable.
//   - On adv, if out_vld & ~out_last: load out_ptr<=next[out_ptr], keep out_id,
//     walk count+1, no grant.
//   - On adv, if ~out_vld | out_last: grant a requester (no-gap list switch).
//   - Grant: lowest index i at/after RR pointer with req_vld[i] & req_start[i]!=0.
//     req_rdy[i]=1 that cycle only. Load out_ptr<=req_start[i], out_id<=i, walk count<=1.
//     RR pointer <= i+1 (mod NREQ).
//   - If no eligible request: out_vld<=0.
//   - NULL start: req_vld with req_start==0 is consumed (req_rdy=1) only when no non-NULL request
//     is eligible. It produces no beat and does not move the RR pointer.
//   - out_last is registered with the beat: next[loaded ptr]==0, OR walk count reaches n.
//     The second case also sets loop_err.
//   - Latency: start accepted in cycle t -> first beat out_vld=1 in t+1.
//     With out_rdy=1 a k-node list occupies exactly k consecutive cycles.
//   - req_rdy is combinational from req_vld, RR pointer, out_vld/out_last/out_rdy.
//     There is no path from req_start to req_rdy except the NULL check.
//   - Config: write next[cfg_addr]<=cfg_next when cfg_we & cfg_rdy. cfg_we while ~cfg_rdy is ignored.
//     next[0] is writable but never followed, since walks stop on 0.
//   - Simultaneous events:
//     - cfg_we in the same cycle as a grant: the write lands; the new beat sees the old table value
//       for its own out_last computation.
//     - Two requesters raising req_vld together: served in RR order, one list each.
//   - loop_err clears only on rst.
// STRUCTURE
//   - Package ll_pkg: n, w_ptr, ptr_t, NULL_PTR='0, req_id_t.
//     ptr_seq_gen and start_req_gen are migrated onto ll_pkg as well.
//   - Sub-module rr_arb #(NREQ): inputs req mask and enable; outputs one-hot grant and index;
//     updates its pointer on enable&|grant.
//   - Next table: flop array of n x w_ptr with one write port and two combinational reads
//     (next[out_ptr] and next[selected start]).
// TESTING
//   - Table 7->15->8->0 and 1->5->3->10->0; req0 start 7, out_rdy=1
//     -> beats 7,15,8 (id0, last on 8) in 3 consecutive cycles.
//   - req0=7 and req1=1 both valid
//     -> 7,15,8 then 1,5,3,10 with no gap; ids 0 then 1; req_rdy[1] asserted on the cycle 8 is out.
//   - out_rdy toggled 1,0,0,1 mid-list -> out_ptr/out_id/out_last hold while stalled; no beat dropped.
//   - RR fairness: all 4 requesters hold a single-node list (start 6, next[6]=0)
//     -> grants 0,1,2,3,0 and beats on every cycle.
//   - Loop: next[2]=4, next[4]=2; start 2 -> 16 beats, 16th has out_last=1, loop_err=1.
//     Next list still served.
//   - req_start=0 on req2 alone -> req_rdy[2]=1, no beat.
//     cfg_we during out_vld -> table unchanged; rst mid-list -> out_vld=0 next cycle, table zeroed.

Source files
------------

// File: rtl/ll_walk_sched_pkg.sv
// Shared types for the linked-list walk scheduler: node count, pointer width and pointer types.
// No logic of its own; helper functions are pure combinational.
// NULL (pointer 0) terminates every list.
package ll_pkg;

   localparam int n         = 16;
   localparam int w_ptr     = $clog2(n);
   localparam int NREQ_DFLT = 4;

   typedef logic [w_ptr-1:0]              ptr_t;
   typedef logic [$clog2(NREQ_DFLT)-1:0]  req_id_t;
   // walk counter must hold the value n itself
   typedef logic [$clog2(n+1)-1:0]        wcnt_t;

   localparam ptr_t NULL_PTR = '0;

   // A start offer is eligible for arbitration only when it points at a real node.
   function automatic logic start_req_gen(input logic vld, input ptr_t start);
      return vld && (start != NULL_PTR);
   endfunction

   // Pointer k positions after base in node-index order, wrapping at n.
   function automatic ptr_t ptr_seq_gen(input ptr_t base, input int unsigned k);
      return ptr_t'((int'(base) + int'(k)) % n);
   endfunction

endpackage

// File: rtl/ll_walk_sched_rr.sv
// Round-robin arbiter: lowest requesting index at/after the rotating pointer wins.
// Latency: grant is combinational; pointer moves to winner+1 on the clock after en & any.
// Backpressure: pointer holds whenever en is low or nothing requests.
// Ports: clk, rst (sync, active-high); req mask, en; gnt one-hot, idx binary, any = some request.
module rr_arb #(
   parameter  int NREQ = 4,
   localparam int IW   = $clog2(NREQ)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   input  logic            en,
   output logic [NREQ-1:0] gnt,
   output logic [IW-1:0]   idx,
   output logic            any
);

   logic [IW-1:0] rr;

   always_comb begin
      int j;
      j   = 0;
      gnt = '0;
      idx = '0;
      any = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         j = (int'(rr) + k) % NREQ;
         if (!any && req[j]) begin
            any = 1'b1;
            idx = IW'(j);
         end
      end
      if (any) gnt[idx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst)
         rr <= '0;
      else if (en && any)
         rr <= (idx == IW'(NREQ-1)) ? '0 : idx + 1'b1;
   end

endmodule

// File: rtl/ll_walk_sched.sv
// Shares one linked-list walker among NREQ requesters; emits one node pointer per accepted beat.
// Latency: start accepted in cycle t gives first beat in t+1; lists follow each other with no gap.
// Backpressure: out_rdy low freezes all outputs and grants; table writes only while no beat is valid.
// Ports: clk, rst (sync, active-high); req_start/req_vld/req_rdy start offers with one-hot grant;
//        cfg_we/cfg_addr/cfg_next/cfg_rdy next-table load; out_ptr/out_id/out_last/out_vld/out_rdy
//        beat stream; loop_err sticky flag for a walk that hit n nodes without reaching NULL.
module ll_walk_sched
   import ll_pkg::*;
#(
   parameter  int NREQ = 4,
   localparam int IW   = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  ptr_t [NREQ-1:0]       req_start,
   input  logic [NREQ-1:0]       req_vld,
   output logic [NREQ-1:0]       req_rdy,
   input  logic                  cfg_we,
   input  ptr_t                  cfg_addr,
   input  ptr_t                  cfg_next,
   output logic                  cfg_rdy,
   output ptr_t                  out_ptr,
   output logic [IW-1:0]         out_id,
   output logic                  out_last,
   output logic                  out_vld,
   input  logic                  out_rdy,
   output logic                  loop_err
);

   ptr_t            tbl [n];
   ptr_t            nxt_q;      // next[out_ptr], captured when out_ptr loads
   wcnt_t           cnt;
   wcnt_t           cnt_inc;
   logic            adv;
   logic            walking;
   logic            grant_en;
   logic [NREQ-1:0] elig;
   logic [NREQ-1:0] arb_gnt;
   logic [NREQ-1:0] null_gnt;
   logic [IW-1:0]   arb_idx;
   logic            arb_any;
   ptr_t            sel_start;
   ptr_t            walk_nn;
   ptr_t            start_nn;

   assign adv      = ~out_vld | out_rdy;
   assign walking  = out_vld & ~out_last;
   assign grant_en = adv & ~walking;
   assign cfg_rdy  = ~out_vld;
   assign cnt_inc  = cnt + wcnt_t'(1);

   always_comb begin
      elig = '0;
      for (int i = 0; i < NREQ; i++)
         elig[i] = start_req_gen(req_vld[i], req_start[i]);
   end

   // NULL starts are only drained when no real list is waiting; every valid offer is NULL then.
   always_comb begin
      logic found;
      found    = 1'b0;
      null_gnt = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (!found && req_vld[i]) begin
            null_gnt[i] = 1'b1;
            found       = 1'b1;
         end
      end
   end

   rr_arb #(.NREQ(NREQ)) u_arb (
      .clk (clk),
      .rst (rst),
      .req (elig),
      .en  (grant_en),
      .gnt (arb_gnt),
      .idx (arb_idx),
      .any (arb_any)
   );

   assign req_rdy   = grant_en ? (arb_any ? arb_gnt : null_gnt) : '0;
   assign sel_start = req_start[arb_idx];

   // The two table reads: successor of the node about to be shown, on either load path.
   // Reading through nxt_q keeps out_last a single lookup away from the loaded pointer.
   assign walk_nn  = tbl[nxt_q];
   assign start_nn = tbl[sel_start];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < n; i++) tbl[i] <= NULL_PTR;
      end else if (cfg_we && cfg_rdy) begin
         tbl[cfg_addr] <= cfg_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_vld  <= 1'b0;
         out_ptr  <= NULL_PTR;
         out_id   <= '0;
         out_last <= 1'b0;
         nxt_q    <= NULL_PTR;
         cnt      <= '0;
         loop_err <= 1'b0;
      end else if (adv) begin
         if (walking) begin
            out_ptr  <= nxt_q;
            nxt_q    <= walk_nn;
            cnt      <= cnt_inc;
            out_last <= (walk_nn == NULL_PTR) || (cnt_inc == wcnt_t'(n));
            if (cnt_inc == wcnt_t'(n)) loop_err <= 1'b1;
         end else if (arb_any) begin
            out_vld  <= 1'b1;
            out_ptr  <= sel_start;
            out_id   <= arb_idx;
            nxt_q    <= start_nn;
            cnt      <= wcnt_t'(1);
            out_last <= (start_nn == NULL_PTR);
         end else begin
            out_vld  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ll_walk_sched.sv
// Bench for ll_walk_sched: directed vector table, hand-written corner sequences and a randomized
// run checked against a list-level reference model (table walk + round-robin order).
module tb_ll_walk_sched;
   import ll_pkg::*;

   localparam int NR = 4;

   logic           clk = 1'b0;
   logic           rst;
   ptr_t [NR-1:0]  req_start;
   logic [NR-1:0]  req_vld;
   logic [NR-1:0]  req_rdy;
   logic           cfg_we;
   ptr_t           cfg_addr;
   ptr_t           cfg_next;
   logic           cfg_rdy;
   ptr_t           out_ptr;
   logic [1:0]     out_id;
   logic           out_last;
   logic           out_vld;
   logic           out_rdy;
   logic           loop_err;

   ll_walk_sched #(.NREQ(NR)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_start (req_start),
      .req_vld   (req_vld),
      .req_rdy   (req_rdy),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_next  (cfg_next),
      .cfg_rdy   (cfg_rdy),
      .out_ptr   (out_ptr),
      .out_id    (out_id),
      .out_last  (out_last),
      .out_vld   (out_vld),
      .out_rdy   (out_rdy),
      .loop_err  (loop_err)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req_vld   = '0;
      req_start = '0;
      cfg_we    = 1'b0;
      cfg_addr  = '0;
      cfg_next  = '0;
      out_rdy   = 1'b1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic cfg_write(input ptr_t a, input ptr_t d);
      cfg_we = 1'b1; cfg_addr = a; cfg_next = d;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic beat_is(input string name, input ptr_t p, input logic [1:0] id, input logic last);
      check(name, 32'({out_vld, out_ptr, out_id, out_last}), 32'({1'b1, p, id, last}));
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic [3:0] vld;
      ptr_t       s0;
      ptr_t       s1;
      logic       ordy;
      logic [3:0] e_rdy;
      logic       e_vld;
      ptr_t       e_ptr;
      logic [1:0] e_id;
      logic       e_last;
   } vec_t;

   vec_t vt [15];

   // ---------------- reference model ----------------
   typedef struct packed {
      ptr_t       p;
      logic [1:0] id;
      logic       last;
   } beat_t;

   ptr_t  mtbl [n];
   beat_t expq [$];
   int    mrr;
   logic  mloop;

   task automatic push_walk(input ptr_t s, input int id);
      ptr_t p;
      logic last;
      p = s;
      for (int c = 1; c <= n; c++) begin
         last = (mtbl[p] == NULL_PTR) || (c == n);
         expq.push_back('{p: p, id: 2'(id), last: last});
         if (c == n) mloop = 1'b1;
         if (last) break;
         p = mtbl[p];
      end
   endtask

   initial begin
      logic [NR-1:0] hs;
      logic          stall_pend;
      logic [7:0]    stall_val;
      logic          grant_pend;
      logic [NR-1:0] elig;
      logic          opp;
      int            k;
      int            wait_cnt;
      beat_t         b;

      vt[0]  = '{4'b0011, 4'd7, 4'd1, 1'b1, 4'b0001, 1'b1, 4'd7,  2'd0, 1'b0};
      vt[1]  = '{4'b0010, 4'd7, 4'd1, 1'b1, 4'b0000, 1'b1, 4'd15, 2'd0, 1'b0};
      vt[2]  = '{4'b0010, 4'd7, 4'd1, 1'b1, 4'b0000, 1'b1, 4'd8,  2'd0, 1'b1};
      vt[3]  = '{4'b0010, 4'd7, 4'd1, 1'b1, 4'b0010, 1'b1, 4'd1,  2'd1, 1'b0};
      vt[4]  = '{4'b0000, 4'd0, 4'd0, 1'b1, 4'b0000, 1'b1, 4'd5,  2'd1, 1'b0};
      vt[5]  = '{4'b0000, 4'd0, 4'd0, 1'b1, 4'b0000, 1'b1, 4'd3,  2'd1, 1'b0};
      vt[6]  = '{4'b0000, 4'd0, 4'd0, 1'b1, 4'b0000, 1'b1, 4'd10, 2'd1, 1'b1};
      vt[7]  = '{4'b0000, 4'd0, 4'd0, 1'b1, 4'b0000, 1'b0, 4'd0,  2'd0, 1'b0};
      vt[8]  = '{4'b0001, 4'd1, 4'd0, 1'b1, 4'b0001, 1'b1, 4'd1,  2'd0, 1'b0};
      vt[9]  = '{4'b0010, 4'd0, 4'd1, 1'b0, 4'b0000, 1'b1, 4'd1,  2'd0, 1'b0};
      vt[10] = '{4'b0010, 4'd0, 4'd1, 1'b0, 4'b0000, 1'b1, 4'd1,  2'd0, 1'b0};
      vt[11] = '{4'b0000, 4'd0, 4'd0, 1'b1, 4'b0000, 1'b1, 4'd5,  2'd0, 1'b0};
      vt[12] = '{4'b0000, 4'd0, 4'd0, 1'b1, 4'b0000, 1'b1, 4'd3,  2'd0, 1'b0};
      vt[13] = '{4'b0000, 4'd0, 4'd0, 1'b1, 4'b0000, 1'b1, 4'd10, 2'd0, 1'b1};
      vt[14] = '{4'b0000, 4'd0, 4'd0, 1'b1, 4'b0000, 1'b0, 4'd0,  2'd0, 1'b0};

      idle_inputs();
      do_reset();

      // reset state
      check("rst_out", 32'({out_vld, out_ptr, out_id, out_last}), 32'(0));
      check("rst_loop_err", 32'(loop_err), 32'(0));
      check("rst_cfg_rdy", 32'(cfg_rdy), 32'(1));
      check("rst_req_rdy", 32'(req_rdy), 32'(0));

      // lists 7->15->8->0 and 1->5->3->10->0
      cfg_write(4'd7, 4'd15);
      cfg_write(4'd15, 4'd8);
      cfg_write(4'd1, 4'd5);
      cfg_write(4'd5, 4'd3);
      cfg_write(4'd3, 4'd10);

      for (int i = 0; i < 15; i++) begin
         req_vld      = vt[i].vld;
         req_start    = '0;
         req_start[0] = vt[i].s0;
         req_start[1] = vt[i].s1;
         out_rdy      = vt[i].ordy;
         #4;
         check($sformatf("vec%0d_rdy", i), 32'(req_rdy), 32'(vt[i].e_rdy));
         tick();
         check($sformatf("vec%0d_vld", i), 32'(out_vld), 32'(vt[i].e_vld));
         if (vt[i].e_vld)
            check($sformatf("vec%0d_beat", i), 32'({out_ptr, out_id, out_last}),
                  32'({vt[i].e_ptr, vt[i].e_id, vt[i].e_last}));
      end
      idle_inputs();

      // round-robin fairness with single-node lists (fresh reset: next[6]=0, pointer at 0)
      do_reset();
      req_vld = 4'b1111;
      for (int i = 0; i < NR; i++) req_start[i] = 4'd6;
      for (int c = 0; c < 5; c++) begin
         #4;
         check($sformatf("rr%0d_rdy", c), 32'(req_rdy), 32'(4'b0001 << (c % 4)));
         tick();
         beat_is($sformatf("rr%0d_beat", c), 4'd6, 2'(c % 4), 1'b1);
      end
      idle_inputs();
      tick();
      check("rr_drain", 32'(out_vld), 32'(0));

      // self-loop 2->4->2: hits the n-node limit
      check("loop_err_pre", 32'(loop_err), 32'(0));
      cfg_write(4'd2, 4'd4);
      cfg_write(4'd4, 4'd2);
      req_vld = 4'b0001; req_start[0] = 4'd2;
      tick();
      req_vld = '0;
      for (int bn = 1; bn <= n; bn++) begin
         beat_is($sformatf("loop_b%0d", bn), (bn % 2 == 1) ? 4'd2 : 4'd4, 2'd0, bn == n);
         check($sformatf("loop_err_b%0d", bn), 32'(loop_err), 32'(bn == n));
         tick();
      end
      req_vld = 4'b0010; req_start[1] = 4'd6;
      tick();
      req_vld = '0;
      beat_is("after_loop", 4'd6, 2'd1, 1'b1);
      check("loop_err_sticky", 32'(loop_err), 32'(1));
      tick();

      // NULL start: consumed, no beat, pointer unchanged (still 2)
      req_vld = 4'b0100; req_start = '0;
      #4;
      check("null_rdy", 32'(req_rdy), 32'(4'b0100));
      tick();
      req_vld = '0;
      check("null_nobeat", 32'(out_vld), 32'(0));
      req_vld = 4'b1100; req_start[2] = 4'd6; req_start[3] = 4'd6;
      #4;
      check("null_rr_hold", 32'(req_rdy), 32'(4'b0100));
      tick();
      req_vld = '0;
      beat_is("null_rr_beat", 4'd6, 2'd2, 1'b1);
      tick();

      // table write attempted while a beat is pending is dropped
      req_vld = 4'b0001; req_start = '0; req_start[0] = 4'd6; out_rdy = 1'b0;
      tick();
      req_vld = '0;
      check("cfg_rdy_busy", 32'(cfg_rdy), 32'(0));
      cfg_we = 1'b1; cfg_addr = 4'd6; cfg_next = 4'd9;
      tick();
      cfg_we = 1'b0; out_rdy = 1'b1;
      beat_is("stall_hold", 4'd6, 2'd0, 1'b1);
      tick();
      req_vld = 4'b0001;
      tick();
      req_vld = '0;
      beat_is("cfg_ignored", 4'd6, 2'd0, 1'b1);
      tick();

      // table write in the grant cycle: beat uses the old successor
      req_vld = 4'b0001; req_start[0] = 4'd6;
      cfg_we = 1'b1; cfg_addr = 4'd6; cfg_next = 4'd3;
      #4;
      check("cfg_grant_rdy", 32'(req_rdy), 32'(4'b0001));
      tick();
      req_vld = '0; cfg_we = 1'b0;
      beat_is("cfg_grant_old", 4'd6, 2'd0, 1'b1);
      tick();
      req_vld = 4'b0001;
      tick();
      req_vld = '0;
      beat_is("cfg_grant_new0", 4'd6, 2'd0, 1'b0);
      tick();
      beat_is("cfg_grant_new1", 4'd3, 2'd0, 1'b1);
      tick();

      // reset mid-walk
      req_vld = 4'b0001; req_start[0] = 4'd2;
      tick();
      req_vld = '0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_mid_vld", 32'(out_vld), 32'(0));
      check("rst_mid_loop_err", 32'(loop_err), 32'(0));
      req_vld = 4'b0001;
      tick();
      req_vld = '0;
      beat_is("rst_tbl_zero", 4'd2, 2'd0, 1'b1);
      tick();

      // ---------------- randomized run against the reference model ----------------
      idle_inputs();
      do_reset();
      mrr   = 0;
      mloop = 1'b0;
      for (int a = 0; a < n; a++) mtbl[a] = NULL_PTR;
      for (int a = 1; a < n; a++) begin
         mtbl[a] = ($urandom % 3 == 0) ? NULL_PTR : ptr_t'($urandom_range(1, n-1));
         cfg_write(ptr_t'(a), mtbl[a]);
      end

      hs         = '0;
      stall_pend = 1'b0;
      stall_val  = '0;
      grant_pend = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int i = 0; i < NR; i++) begin
            if (hs[i]) req_vld[i] = 1'b0;
            if (!req_vld[i] && cyc < 2700 && $urandom % 3 == 0) begin
               req_vld[i]   = 1'b1;
               req_start[i] = ($urandom % 6 == 0) ? NULL_PTR : ptr_t'($urandom_range(1, n-1));
            end
         end
         out_rdy = (cyc < 2700) ? ($urandom % 4 != 0) : 1'b1;
         #4;
         if (stall_pend)
            check("rnd_hold", 32'({out_vld, out_ptr, out_id, out_last}), 32'(stall_val));
         if (grant_pend)
            check("rnd_no_gap", 32'(out_vld), 32'(1));
         grant_pend = 1'b0;
         opp = !out_vld || (out_last && out_rdy);
         check("rnd_grant_gate", 32'(|req_rdy), 32'(opp && (|req_vld)));
         hs = req_vld & req_rdy;
         if (req_rdy != '0) begin
            check("rnd_onehot", 32'({$onehot(req_rdy), |(req_rdy & ~req_vld)}), 32'(2'b10));
            for (int i = 0; i < NR; i++) elig[i] = req_vld[i] && (req_start[i] != NULL_PTR);
            if (elig != '0) begin
               k = 0;
               for (int j = NR-1; j >= 0; j--)
                  if (elig[(mrr + j) % NR]) k = (mrr + j) % NR;
               check("rnd_rr_pick", 32'(req_rdy), 32'(4'b0001 << k));
               push_walk(req_start[k], k);
               mrr = (k + 1) % NR;
               grant_pend = 1'b1;
            end else begin
               for (int i = 0; i < NR; i++)
                  if (req_rdy[i]) check("rnd_null_pick", 32'(req_start[i]), 32'(0));
            end
         end
         if (out_vld && out_rdy) begin
            if (expq.size() == 0) begin
               check("rnd_extra_beat", 32'(out_ptr), 32'(0));
               if (out_ptr == 4'd0) check("rnd_extra_beat", 32'(1), 32'(0));
            end else begin
               b = expq.pop_front();
               check("rnd_beat", 32'({out_ptr, out_id, out_last}), 32'(b));
            end
         end
         stall_pend = out_vld && !out_rdy;
         stall_val  = {1'b0, out_vld, out_ptr, out_id, out_last};
         tick();
      end

      wait_cnt = 0;
      while (out_vld && wait_cnt < 100) begin
         tick();
         wait_cnt++;
      end
      check("rnd_drained", 32'({out_vld, 1'b0}), 32'(0));
      check("rnd_queue_empty", 32'(expq.size()), 32'(0));
      check("rnd_loop_err", 32'(loop_err), 32'(mloop));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
